// File: rtl/ifm_reg_load_ctrl.sv
// ifm_reg_load_ctrl: steers handshaked IFM words into a bank of NUM_REGS registers, one register per transfer.
// Optional macro IFM_REG_OVERRUN_EN adds a sticky overrun flag (ports overrun_clr, overrun).
module ifm_reg_load_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 10,
    parameter int STATE_W    = 4,
    parameter int LOAD_STATE = 3,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STATE_W-1:0]    current_state,
    input  logic                  start,
    input  logic                  ifm_valid,
    input  logic [DATA_WIDTH-1:0] ifm_data,
    output logic                  ifm_ready,
    output logic [NUM_REGS-1:0]   reg_we,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic [IDX_W-1:0]      wr_idx,
    output logic                  busy,
    output logic                  load_done
`ifdef IFM_REG_OVERRUN_EN
    ,
    input  logic                  overrun_clr,
    output logic                  overrun
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} fsm_t;
    fsm_t state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [NUM_REGS-1:0] reg_we_q, reg_we_d;
    logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
    logic load_done_q, load_done_d;
    logic in_load_state, xfer, last;
    assign in_load_state = current_state == STATE_W'(LOAD_STATE);
    assign ifm_ready = state_q == LOAD && in_load_state;
    assign xfer = ifm_valid && ifm_ready;
    assign last = wr_idx_q == IDX_W'(NUM_REGS - 1);
    assign busy = state_q != IDLE;
    assign wr_idx = wr_idx_q;
    assign reg_we = reg_we_q;
    assign reg_wdata = reg_wdata_q;
    assign load_done = load_done_q;
    // Next state and index: start gated by controller state, abort on leaving it, wrap after the last register.
    always_comb begin
        state_d = state_q;
        wr_idx_d = wr_idx_q;
        case (state_q)
            IDLE: begin
                if (start && in_load_state) begin
                    state_d = LOAD;
                    wr_idx_d = '0;
                end
            end
            LOAD: begin
                if (!in_load_state) begin
                    state_d = IDLE;
                    wr_idx_d = '0;
                end else if (xfer) begin
                    state_d = last ? DONE : LOAD;
                    wr_idx_d = last ? '0 : wr_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        reg_we_d = xfer ? NUM_REGS'(1) << wr_idx_q : '0;
        reg_wdata_d = xfer ? ifm_data : reg_wdata_q;
        load_done_d = state_q == DONE;
    end
    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_idx_q <= '0;
            reg_we_q <= '0;
            reg_wdata_q <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_idx_q <= wr_idx_d;
            reg_we_q <= reg_we_d;
            reg_wdata_q <= reg_wdata_d;
            load_done_q <= load_done_d;
        end
    end
`ifdef IFM_REG_OVERRUN_EN
    logic overrun_q, overrun_d;
    assign overrun = overrun_q;
    // Sticky flag for words offered when no bank load can take them; set beats clear.
    always_comb begin
        overrun_d = (ifm_valid && (state_q == DONE || (state_q == IDLE && in_load_state))) ? 1'b1 :
                    overrun_clr ? 1'b0 : overrun_q;
    end
    // Overrun flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overrun_q <= 1'b0;
        else overrun_q <= overrun_d;
    end
`endif
endmodule

// File: tb/tb_ifm_reg_load_ctrl.sv
// tb_ifm_reg_load_ctrl: scoreboard bench with directed scenarios and random traffic against a counting reference model.
module tb_ifm_reg_load_ctrl;
    localparam int N = 10;
    localparam int DW = 32;
    logic clk = 0;
    logic rst = 1;
    logic [3:0] current_state = 0;
    logic start = 0;
    logic ifm_valid = 0;
    logic [DW-1:0] ifm_data = 0;
    logic ifm_ready;
    logic [N-1:0] reg_we;
    logic [DW-1:0] reg_wdata;
    logic [3:0] wr_idx;
    logic busy;
    logic load_done;
`ifdef IFM_REG_OVERRUN_EN
    logic overrun_clr = 0;
    logic overrun;
    bit m_ov = 0;
`endif
    int tests = 0;
    int fails = 0;

    ifm_reg_load_ctrl dut (
        .clk(clk), .rst(rst), .current_state(current_state), .start(start),
        .ifm_valid(ifm_valid), .ifm_data(ifm_data), .ifm_ready(ifm_ready),
        .reg_we(reg_we), .reg_wdata(reg_wdata), .wr_idx(wr_idx), .busy(busy),
        .load_done(load_done)
`ifdef IFM_REG_OVERRUN_EN
        , .overrun_clr(overrun_clr), .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        logic [DW-1:0] d;
    } wr_t;
    wr_t exp_q[$];

    // Reference model: a load is "active" with a count of words taken so far;
    // the bank completes after N words, followed by one DONE cycle and then the done pulse.
    bit m_active = 0, m_done = 0, m_ld = 0, ov_set;
    int m_idx = 0;
    logic [DW-1:0] m_wd = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_done = 0; m_ld = 0; m_idx = 0; m_wd = 0;
            exp_q.delete();
`ifdef IFM_REG_OVERRUN_EN
            m_ov = 0;
`endif
        end else begin
            ov_set = ifm_valid && (m_done || (!m_active && current_state == 3));
`ifdef IFM_REG_OVERRUN_EN
            m_ov = ov_set ? 1'b1 : overrun_clr ? 1'b0 : m_ov;
`endif
            m_ld = m_done;
            if (m_done) m_done = 0;
            else if (m_active) begin
                if (current_state != 3) begin
                    m_active = 0; m_idx = 0;
                end else if (ifm_valid) begin
                    exp_q.push_back('{m_idx, ifm_data});
                    m_wd = ifm_data;
                    if (m_idx == N - 1) begin
                        m_active = 0; m_idx = 0; m_done = 1;
                    end else m_idx++;
                end
            end else if (start && current_state == 3) begin
                m_active = 1; m_idx = 0;
            end
        end
    end

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        wr_t w;
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("reg_we_onehot", 64'(reg_we), 64'(1) << w.idx);
            chk("reg_wdata_write", 64'(reg_wdata), 64'(w.d));
        end else begin
            chk("reg_we_idle", 64'(reg_we), 64'd0);
            chk("reg_wdata_hold", 64'(reg_wdata), 64'(m_wd));
        end
        chk("ifm_ready", 64'(ifm_ready), 64'(m_active && current_state == 3));
        chk("busy", 64'(busy), 64'(m_active || m_done));
        chk("wr_idx", 64'(wr_idx), 64'(m_idx));
        chk("load_done", 64'(load_done), 64'(m_ld));
`ifdef IFM_REG_OVERRUN_EN
        chk("overrun", 64'(overrun), 64'(m_ov));
`endif
    end

    task automatic cyc(input bit s, input int cs, input bit v, input logic [DW-1:0] d, input bit clr = 0);
        start = s;
        current_state = 4'(cs);
        ifm_valid = v;
        ifm_data = d;
`ifdef IFM_REG_OVERRUN_EN
        overrun_clr = clr;
`else
        if (clr) ifm_data = d;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (2) cyc(0, 3, 0, 0);
        // basic load, back-to-back start in the load_done cycle
        cyc(1, 3, 0, 0);
        for (int i = 0; i < N; i++) cyc(0, 3, 1, 32'h100 + 32'(i));
        cyc(0, 3, 0, 0);
        cyc(1, 3, 0, 0);
        // bubbles with a start issued mid-load
        for (int i = 0; i < 3 * N; i++) cyc(i == 5, 3, i % 3 == 0, 32'h200 + 32'(i / 3));
        repeat (3) cyc(0, 3, 0, 0);
        // abort after four accepts
        cyc(1, 3, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 3, 1, 32'h300 + 32'(i));
        cyc(0, 5, 1, 32'h3ff);
        repeat (3) cyc(0, 5, 0, 0);
        // start gated by controller state
        cyc(1, 2, 0, 0);
        repeat (2) cyc(0, 2, 0, 0);
        // overrun: source keeps pushing past the bank, then clear
        cyc(1, 3, 0, 0);
        for (int i = 0; i < N + 2; i++) cyc(0, 3, 1, 32'h400 + 32'(i));
        cyc(0, 3, 0, 0);
        cyc(0, 3, 0, 0, 1);
        repeat (2) cyc(0, 3, 0, 0);
        // asynchronous reset mid-load at wr_idx 4
        cyc(1, 3, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 3, 1, 32'h500 + 32'(i));
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("rst_reg_we", 64'(reg_we), 64'd0);
        chk("rst_reg_wdata", 64'(reg_wdata), 64'd0);
        chk("rst_wr_idx", 64'(wr_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(ifm_ready), 64'd0);
        chk("rst_load_done", 64'(load_done), 64'd0);
        @(posedge clk);
        #1 rst = 0;
        cyc(0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 7) == 0, ($urandom_range(0, 7) < 7) ? 3 : int'($urandom_range(0, 15)),
                $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 7) == 0);
        repeat (4) cyc(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ifm_reg_load_ctrl.md
Name: ifm_reg_load_ctrl

Overview:
Sequential, parametrised successor to the fixed 10-entry IFM register write decoder. It accepts IFM words over a valid/ready handshake while the conv controller is in the load state. Each accepted word is steered to the next register of a bank of NUM_REGS IFM registers through a registered one-hot write enable and a data bus. The block sits between the IFM buffer read port and the IFM register bank, and reports completion to the conv controller FSM.

Parameters:
DATA_WIDTH, 32, width of an IFM word / register.
NUM_REGS, 10, number of IFM registers (2..64).
STATE_W, 4, width of the conv controller state bus.
LOAD_STATE, 3, controller state code in which loading is permitted.
IDX_W, $clog2(NUM_REGS), width of the write index.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset, asynchronous, active-high.
current_state  input  STATE_W  conv controller state.
start  input  1  single-cycle request to begin one bank load.
ifm_valid  input  1  ifm_data valid.
ifm_data  input  DATA_WIDTH  IFM word.
ifm_ready  output  1  block accepts a word this cycle.
reg_we  output  NUM_REGS  registered one-hot write enable; bit i writes register i.
reg_wdata  output  DATA_WIDTH  registered write data.
wr_idx  output  IDX_W  index of the next register to be written.
busy  output  1  FSM not in IDLE.
load_done  output  1  single-cycle pulse after register NUM_REGS-1 is written.

Behaviour:
- Reset (async assert): FSM=IDLE. ifm_ready=0, reg_we=0, reg_wdata=0, wr_idx=0, busy=0, load_done=0.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - ifm_ready=0.
  - start=1 with current_state==LOAD_STATE -> LOAD, wr_idx=0.
  - start in any other state code is ignored.
- LOAD:
  - ifm_ready = (current_state==LOAD_STATE); combinational from FSM and current_state.
  - A transfer occurs when ifm_valid & ifm_ready. In the next cycle, reg_we[wr_idx]=1 and reg_wdata=ifm_data of that transfer. Latency is 1 cycle.
  - Each transfer increments wr_idx.
  - Transfer with wr_idx==NUM_REGS-1 -> DONE; wr_idx wraps to 0.
  - No transfer in a cycle -> reg_we=0 next cycle. Gaps in ifm_valid of any length are allowed.
  - current_state != LOAD_STATE while in LOAD -> abort to IDLE, wr_idx=0, no load_done.
  - A word accepted in the cycle before the abort is still written.
- DONE: load_done=1 for exactly one cycle, ifm_ready=0, unconditional -> IDLE next cycle.
- start while busy=1 is ignored; no queuing.
- reg_we is never multi-hot. reg_we=0 in every cycle not following a transfer.
- reg_wdata holds its last value when reg_we=0.
- Back-to-back loads: a start in the cycle after load_done (FSM in IDLE) is honoured. Minimum bank load time is NUM_REGS+2 cycles from start to load_done.
- NUM_REGS not a power of two: wr_idx never exceeds NUM_REGS-1.

Optional Feature:
IFM_REG_OVERRUN_EN.
- Defined:
  - Adds output overrun (1 bit, reset 0) and input overrun_clr (1 bit).
  - overrun sets sticky when ifm_valid=1 while the FSM is in DONE or IDLE with current_state==LOAD_STATE. This means the source is pushing more words than the bank holds.
  - overrun clears on overrun_clr=1; set has priority over clear in the same cycle.
  - No effect on the data path.
- Not defined: ports absent, no extra logic.

Test Plan:
- Reset: assert rst mid-load (wr_idx=4) -> all outputs 0 asynchronously; FSM IDLE after release.
- Basic load: NUM_REGS=10, current_state=3, start, ifm_valid held 1 with data 0x100..0x109 -> reg_we one-hot bits 0..9 in 10 consecutive cycles, each carrying 0x100+i. load_done pulses 1 cycle after bit 9. ifm_ready=0 in DONE.
- Bubbles: ifm_valid toggled 1,0,0,1,... -> reg_we asserted only in cycles after accepts; order still 0..9; wr_idx stalls during gaps.
- Abort: current_state changes 3->5 after 4 accepts -> ifm_ready drops the same cycle; reg_we bit 3 still fires; no load_done; wr_idx=0.
- Start gating: start with current_state=2 -> stays IDLE, busy=0. start during LOAD -> ignored, sequence unchanged. start in the cycle after load_done -> new load from index 0.
- Overrun (IFM_REG_OVERRUN_EN defined): ifm_valid=1 in DONE cycle -> overrun=1 next cycle and held. overrun_clr=1 -> overrun=0 next cycle.
